quiz_vector_checker: RTL and testbench
======================================

// Module: quiz_vector_checker
// PURPOSE
//  Synthesizable stimulus/response engine for small combinational quiz blocks.
//  Sweeps an IN_W-bit input vector 0..2^IN_W-1 into the block under test and
//  captures its OUT_W-bit response after a settle time. Compares each response
//  against a packed expected table and reports pass/fail, the error count and
//  the first failing index. Sits on the response side of the block under test.
// PARAMETERS
//  IN_W      3      stimulus width; vectors run 0..2^IN_W-1
//  OUT_W     6      response width
//  DWELL     4      cycles each vector is held (>= SETTLE+1)
//  SETTLE    2      cycles from stim change to response sample (>= 1)
//  EXP_TABLE 0      packed expected responses; entry i = EXP_TABLE[i*OUT_W +: OUT_W]
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle pulse; starts a sweep (ignored unless IDLE or DONE)
//  stim          out  IN_W     vector driven to block under test
//  resp          in   OUT_W    response from block under test
//  busy          out  1        high in DRIVE/SAMPLE/HOLD
//  sample_valid  out  1        1-cycle pulse when a response is captured
//  sample_data   out  OUT_W    captured response (valid with sample_valid, held after)
//  done          out  1        high in DONE until next start
//  pass          out  1        valid with done: err_count == 0
//  err_count     out  IN_W+1   mismatch count for current sweep
//  first_err_idx out  IN_W     index of first mismatch; 0 if none
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE; stim, sample_data, err_count,
//    first_err_idx = 0; busy, sample_valid, done, pass = 0. Reset mid-sweep aborts it.
//  - FSM: IDLE -start-> DRIVE; DRIVE -(cnt==SETTLE-1)-> SAMPLE; SAMPLE -> HOLD;
//    HOLD -(cnt==DWELL-1)-> DRIVE (idx+1), or DONE if idx==2^IN_W-1;
//    DONE -start-> DRIVE. DONE otherwise holds; start during busy is ignored.
//  - cnt: dwell counter, cleared on each DRIVE entry, +1 every cycle in DRIVE/SAMPLE/HOLD.
//  - stim = idx, registered; updates on the edge entering DRIVE. Total per vector = DWELL cycles.
//  - SAMPLE: resp registered into sample_data; sample_valid high for that one cycle.
//    Compare is on the registered value; on mismatch err_count += 1, and if it is the
//    first mismatch, first_err_idx = idx.
//  - Compare result is visible on the cycle after sample_valid.
//  - Start (from IDLE or DONE): idx, err_count, first_err_idx cleared; done, pass cleared same edge.
//  - done asserts on the edge after the last HOLD cycle.
//  - Sweep length = 2^IN_W*DWELL cycles from start to done (+1 entry cycle).
//  - err_count saturates at 2^IN_W (cannot overflow; width IN_W+1).
//  - idx does not wrap; it stops at 2^IN_W-1.
// CONFIGURATION
//  - QUIZ_CHK_STOP_ON_ERR_EN defined: first mismatch moves SAMPLE -> DONE directly.
//    err_count = 1, pass = 0; stim holds the failing vector.
//  - Not defined: the sweep always covers all 2^IN_W vectors.
// TESTING
//  - Reset: rst_n=0 mid-DRIVE -> all outputs 0 immediately, state IDLE; start after
//    release -> stim=0 next cycle.
//  - Pass sweep: resp = identity-mapped model, EXP_TABLE matching, DWELL=4, SETTLE=2
//    -> 8 sample_valid pulses 4 cycles apart; done=1, pass=1, err_count=0 at cycle 33.
//  - Single fault: model corrupts output for stim=5 -> err_count=1, first_err_idx=5, pass=0.
//  - All fault: resp tied to ~expected -> err_count=8, first_err_idx=0.
//    Restart from DONE clears the counters.
//  - Start during busy: pulse start at cycle 10 -> ignored; sweep timing unchanged.
//  - QUIZ_CHK_STOP_ON_ERR_EN: fault at stim=3 -> done on the cycle after sample 3,
//    stim=3, err_count=1.

Source files
------------

// File: rtl/quiz_vector_checker.sv
// Sweeps every IN_W-bit stimulus into a combinational block and checks each response against EXP_TABLE.
// Optional: define QUIZ_CHK_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module quiz_vector_checker #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 6,
    parameter int DWELL  = 4,
    parameter int SETTLE = 2,
    parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             sample_valid,
    output logic [OUT_W-1:0] sample_data,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  first_err_idx
);
    // state  | meaning
    // IDLE   | waiting for the first start after reset
    // DRIVE  | stim applied, block under test settling
    // SAMPLE | sample_data holds the captured response, compare this cycle
    // HOLD   | pad the vector out to DWELL cycles
    // DONE   | sweep finished, results held until next start
    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, HOLD, DONE} state_t;

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0]   SET_LAST   = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [IN_W-1:0] IDX_LAST   = {IN_W{1'b1}};
    localparam logic [IN_W:0]   ERR_MAX    = {1'b1, {IN_W{1'b0}}};

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [IN_W-1:0]   idx;
    logic [OUT_W-1:0]  exp_word;
    logic              mismatch;
    logic              start_sweep;

    assign stim        = idx;
    assign busy        = (state == DRIVE) || (state == SAMPLE) || (state == HOLD);
    assign done        = (state == DONE);
    assign pass        = done && (err_count == '0);
    assign start_sweep = start && ((state == IDLE) || (state == DONE));
    assign exp_word    = EXP_TABLE[idx*OUT_W +: OUT_W];
    assign mismatch    = (sample_data != exp_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = DRIVE;
            DRIVE:  if (cnt == SET_LAST) state_nxt = SAMPLE;
`ifdef QUIZ_CHK_STOP_ON_ERR_EN
            SAMPLE: state_nxt = mismatch ? DONE : HOLD;
`else
            SAMPLE: state_nxt = HOLD;
`endif
            // >= keeps DWELL == SETTLE+1 from stalling; the vector then takes SETTLE+2 cycles
            HOLD:   if (cnt >= DWELL_LAST) state_nxt = (idx == IDX_LAST) ? DONE : DRIVE;
            DONE:   if (start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (start_sweep) begin
                cnt           <= '0;
                idx           <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
            end else begin
                case (state)
                    DRIVE: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SET_LAST) begin
                            sample_data  <= resp;
                            sample_valid <= 1'b1;
                        end
                    end
                    SAMPLE: begin
                        cnt <= cnt + 1'b1;
                        if (mismatch) begin
                            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                            if (err_count == '0)      first_err_idx <= idx;
                        end
                    end
                    HOLD: begin
                        if ((cnt >= DWELL_LAST) && (idx != IDX_LAST)) begin
                            idx <= idx + 1'b1;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_quiz_vector_checker.sv
// Randomized sweeps of quiz_vector_checker against a per-sweep model of expected samples, timing and results.
// Follows QUIZ_CHK_STOP_ON_ERR_EN the same way the design does.
module tb_quiz_vector_checker;
    localparam int IN_W = 3, OUT_W = 6, DWELL = 4, SETTLE = 2, NV = 8;
    localparam logic [NV*OUT_W-1:0] EXP_PACKED =
        {6'h11, 6'h3f, 6'h23, 6'h1c, 6'h38, 6'h07, 6'h2a, 6'h15};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic             busy, sample_valid, done, pass;
    logic [OUT_W-1:0] sample_data;
    logic [IN_W:0]    err_count;
    logic [IN_W-1:0]  first_err_idx;

    logic [OUT_W-1:0] exp_tbl [NV];
    logic [OUT_W-1:0] mask [NV];
    int total = 0, bad = 0;

`ifdef QUIZ_CHK_STOP_ON_ERR_EN
    localparam bit STOP_MODE = 1'b1;
`else
    localparam bit STOP_MODE = 1'b0;
`endif

    quiz_vector_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DWELL(DWELL), .SETTLE(SETTLE), .EXP_TABLE(EXP_PACKED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
        .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
        .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // block under test: expected table with an optional per-vector corruption
    assign resp = exp_tbl[stim] ^ mask[stim];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input int busy_start_at);
        int k, nsamp, nexp, exp_err, exp_first, exp_done_k;
        nexp = NV; exp_err = 0; exp_first = 0;
        for (int i = 0; i < NV; i++) begin
            if (mask[i] != '0) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
                if (STOP_MODE) begin
                    nexp = i + 1;
                    break;
                end
            end
        end
        exp_done_k = (STOP_MODE && exp_err > 0) ? DWELL*(nexp-1) + SETTLE + 1 : DWELL*nexp;

        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("start_stim", 32'(stim), 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_err", 32'(err_count), 0);
        chk("start_done", 32'(done), 0);
        chk("start_first", 32'(first_err_idx), 0);
        k = 0; nsamp = 0;
        while (!done && k < 200) begin
            start = (k == busy_start_at);
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
            if (sample_valid) begin
                chk("sample_time", 32'(k), 32'(DWELL*nsamp + SETTLE));
                if (nsamp < NV) chk("sample_data", 32'(sample_data), 32'(exp_tbl[nsamp] ^ mask[nsamp]));
                nsamp++;
            end
        end
        if (k >= 200) chk("timeout", 32'(k), 32'(exp_done_k));
        chk("done_time", 32'(k), 32'(exp_done_k));
        chk("samples", 32'(nsamp), 32'(nexp));
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("first_err", 32'(first_err_idx), 32'(exp_first));
        chk("pass", 32'(pass), 32'(exp_err == 0));
        chk("end_stim", 32'(stim), 32'(nexp - 1));
        chk("end_busy", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            exp_tbl[i] = EXP_PACKED[i*OUT_W +: OUT_W];
            mask[i] = '0;
        end
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stim", 32'(stim), 0);
        @(negedge clk); rst_n = 1'b1;

        run_sweep(-1);

        // reset mid-sweep while DRIVE on vector 2
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stim", 32'(stim), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(sample_valid), 0);
        chk("mid_rst_data", 32'(sample_data), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_pass", 32'(pass), 0);
        chk("mid_rst_err", 32'(err_count), 0);
        chk("mid_rst_first", 32'(first_err_idx), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_holds", 32'(busy), 0);

        mask[5] = 6'h04;
        run_sweep(-1);

        for (int i = 0; i < NV; i++) mask[i] = 6'h3f;
        run_sweep(-1);

        for (int i = 0; i < NV; i++) mask[i] = '0;
        mask[3] = 6'h20;
        run_sweep(10);

        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < NV; i++)
                mask[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_sweep((s % 2 == 0) ? int'($urandom_range(1, 30)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
